output_unit_controller: RTL
===========================

OUTPUT_UNIT_CONTROLLER -- requirements
Module: output_unit_controller

Interface
REQ-001 SHALL have parameter CREDIT_DEPTH, default 4, depth in flits of the downstream input-unit FIFO (legal range 1..15).
REQ-002 SHALL have parameter CNT_W, default 3, credit counter width; must satisfy 2^CNT_W > CREDIT_DEPTH.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 credit_decre  input  1  OR of all input units' decrement bits for this port; one flit granted this cycle.
REQ-006 st_valid  input  1  crossbar output valid for this port.
REQ-007 st_data  input  `ROUTER_WIDTH  crossbar output flit.
REQ-008 credit_in  input  1  credit-return pulse from the downstream input unit; one FIFO slot freed.
REQ-009 credit_avail  output  1  at least one downstream slot free; fans out to input units.
REQ-010 credit_count  output  CNT_W  current credit count.
REQ-011 out_valid  output  1  link flit valid to downstream.
REQ-012 out_data  output  `ROUTER_WIDTH  link flit to downstream.
REQ-013 credit_err  output  1  sticky protocol-error flag.

Function
REQ-014 Credit counter SHALL update on each clk edge: decre only -> cnt-1; credit_in only -> cnt+1; both or neither -> unchanged.
REQ-015 credit_avail SHALL be (cnt != 0), driven from the counter register, no combinational path from any input.
REQ-016 credit_count SHALL equal the counter register.
REQ-017 Counter SHALL saturate: decrement at 0 leaves 0; increment at CREDIT_DEPTH leaves CREDIT_DEPTH.
REQ-018 out_valid SHALL be st_valid delayed by exactly one cycle.
REQ-019 out_data SHALL load st_data when st_valid=1 and hold its value otherwise.
REQ-020 One flit per cycle maximum; back-to-back st_valid SHALL produce back-to-back out_valid with no bubble.
REQ-021 Link-state FSM SHALL have states IDLE and SEND: IDLE->SEND on st_valid; SEND->SEND on st_valid; SEND->IDLE on !st_valid; out_valid=1 exactly in SEND.
REQ-022 A credit_decre at cycle n SHALL be followed by st_valid at cycle n+1 (timing of the upstream grant/switch-traversal pipeline).
REQ-023 credit_err SHALL be 0 whenever CREDIT_ERR_CHK_EN is undefined.

Reset
REQ-024 While rst=1: cnt=CREDIT_DEPTH, credit_avail=1, FSM=IDLE, out_valid=0, out_data=0, credit_err=0.
REQ-025 Reset mid-transfer SHALL drop any in-flight flit (out_valid=0 next cycle) and restore full credits; no partial state survives.

Configuration
REQ-026 Macro CREDIT_ERR_CHK_EN defined: credit_err SHALL set one cycle after any of: decre-only at cnt=0 (underflow), credit_in-only at cnt=CREDIT_DEPTH (overflow), st_valid without credit_decre in the previous cycle (orphan flit); cleared only by rst.
REQ-027 Macro CREDIT_ERR_CHK_EN undefined: checker logic SHALL be absent and credit_err tied to 0; all other behaviour identical.

Structure
REQ-028 `ROUTER_WIDTH, `DIRECTION and default CREDIT_DEPTH SHALL live in shared header router.vh; FSM state encodings SHALL be local to this module.
REQ-029 Credit counter (REQ-014..017 plus underflow/overflow flags) SHALL be sub-module credit_counter, parameterised by CREDIT_DEPTH and CNT_W.

Verification
REQ-030 Reset release with CREDIT_DEPTH=4 -> credit_count=4, credit_avail=1, out_valid=0, credit_err=0.
REQ-031 4 decre pulses (each followed by st_valid with data 'h1..'h4), no credit_in -> credit_count 3,2,1,0; credit_avail=0 after 4th edge; out_data 'h1..'h4 on consecutive cycles, out_valid held 1 for 4 cycles.
REQ-032 At cnt=0, credit_in pulse -> credit_count=1, credit_avail=1 on the following cycle.
REQ-033 At cnt=2, credit_decre and credit_in same cycle -> credit_count stays 2, credit_err stays 0.
REQ-034 With CREDIT_ERR_CHK_EN: decre at cnt=0 -> cnt stays 0, credit_err=1 next cycle and stays 1 until rst; credit_in at cnt=4 -> same; st_valid with no preceding decre -> same. Without macro: same stimulus -> credit_err=0.
REQ-035 rst asserted asynchronously mid-burst at cnt=1 with out_valid=1 -> out_valid=0, credit_count=4 immediately, FSM IDLE.

Source files
------------

// File: rtl/output_unit_controller_pkg.sv
// Shared router definitions and output-unit types.
// Macro CREDIT_ERR_CHK_EN (see output_unit_controller.sv) enables the credit protocol checker.
`ifndef ROUTER_VH
`define ROUTER_VH
`define ROUTER_WIDTH 32
`define DIRECTION 5
`define CREDIT_DEPTH_DEFAULT 4
`endif

package output_unit_controller_pkg;

   localparam int unsigned OUC_CREDIT_DEPTH = `CREDIT_DEPTH_DEFAULT;
   localparam int unsigned OUC_CNT_W        = 3;

   typedef struct packed {
      logic underflow;
      logic overflow;
   } credit_flags_t;

   // A flit arriving on the switch without a grant one cycle earlier.
   function automatic logic credit_orphan(input logic st_valid, input logic prev_decre);
      return st_valid & ~prev_decre;
   endfunction

endpackage

// File: rtl/output_unit_controller_credit_counter.sv
// Saturating downstream credit counter with registered availability and
// same-cycle underflow/overflow indications.
module credit_counter
   import output_unit_controller_pkg::*;
#(
   parameter int unsigned CREDIT_DEPTH = OUC_CREDIT_DEPTH,
   parameter int unsigned CNT_W        = OUC_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_decre,
   input  logic             i_incr,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_avail,
   output credit_flags_t    o_flags
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_avail;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_at_zero;
   logic             w_at_full;

   assign w_at_zero = (r_cnt == CNT_W'(0));
   assign w_at_full = (r_cnt == CNT_W'(CREDIT_DEPTH));

   // Next count: a simultaneous grant and return cancel out; both ends saturate.
   always_comb begin
      w_cnt_next = r_cnt;
      case ({i_decre, i_incr})
         2'b10: begin
            if (!w_at_zero) w_cnt_next = r_cnt - CNT_W'(1);
            else            w_cnt_next = r_cnt;
         end
         2'b01: begin
            if (!w_at_full) w_cnt_next = r_cnt + CNT_W'(1);
            else            w_cnt_next = r_cnt;
         end
         default: w_cnt_next = r_cnt;
      endcase
   end

   // Count and availability registers, full credit out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= CNT_W'(CREDIT_DEPTH);
         r_avail <= 1'b1;
      end else begin
         r_cnt   <= w_cnt_next;
         r_avail <= (w_cnt_next != CNT_W'(0));
      end
   end

   assign o_cnt             = r_cnt;
   assign o_avail           = r_avail;
   assign o_flags.underflow = i_decre & ~i_incr & w_at_zero;
   assign o_flags.overflow  = i_incr & ~i_decre & w_at_full;

endmodule

// File: rtl/output_unit_controller.sv
// Router output unit: credit tracking toward the downstream input unit and a
// one-stage link register. Define CREDIT_ERR_CHK_EN to enable the sticky credit_err checker.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 32
`endif

module output_unit_controller
   import output_unit_controller_pkg::*;
#(
   parameter int unsigned CREDIT_DEPTH = OUC_CREDIT_DEPTH,
   parameter int unsigned CNT_W        = OUC_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     credit_decre,
   input  logic                     st_valid,
   input  logic [`ROUTER_WIDTH-1:0] st_data,
   input  logic                     credit_in,
   output logic                     credit_avail,
   output logic [CNT_W-1:0]         credit_count,
   output logic                     out_valid,
   output logic [`ROUTER_WIDTH-1:0] out_data,
   output logic                     credit_err
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } link_state_t;

   link_state_t                r_state;
   link_state_t                w_state_next;
   logic [`ROUTER_WIDTH-1:0]   r_data;
   credit_flags_t              w_flags;

   credit_counter #(
      .CREDIT_DEPTH (CREDIT_DEPTH),
      .CNT_W        (CNT_W)
   ) u_credit_counter (
      .clk     (clk),
      .rst     (rst),
      .i_decre (credit_decre),
      .i_incr  (credit_in),
      .o_cnt   (credit_count),
      .o_avail (credit_avail),
      .o_flags (w_flags)
   );

   // Link state: SEND for every cycle following an accepted switch flit.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (st_valid) w_state_next = SEND;
            else          w_state_next = IDLE;
         end
         SEND: begin
            if (st_valid) w_state_next = SEND;
            else          w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Link state and flit registers; data holds while no flit arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_data  <= '0;
      end else begin
         r_state <= w_state_next;
         if (st_valid) r_data <= st_data;
         else          r_data <= r_data;
      end
   end

   assign out_valid = (r_state == SEND);
   assign out_data  = r_data;

`ifdef CREDIT_ERR_CHK_EN
   logic r_decre_d;
   logic r_err;

   // Sticky protocol error; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_decre_d <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_decre_d <= credit_decre;
         r_err     <= r_err | w_flags.underflow | w_flags.overflow
                      | credit_orphan(st_valid, r_decre_d);
      end
   end

   assign credit_err = r_err;
`else
   logic w_unused_flags;
   assign w_unused_flags = ^w_flags;
   assign credit_err     = 1'b0;
`endif

endmodule
